// File: rtl/modular_addsub_pipe.sv
// Multi-lane modular add/subtract, two-stage valid/ready pipeline (raw result, then correction).
// Optional sticky operand range check enabled by defining MODADDSUB_RANGE_CHECK_EN.
module modular_addsub_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int M          = 12289,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mode,
    input  logic [LANES*DATA_WIDTH-1:0] x_in,
    input  logic [LANES*DATA_WIDTH-1:0] y_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] z_out,
    output logic                        range_err
);

    localparam int                    W   = DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] M_W = DATA_WIDTH'(M);

    // Both corrections fit in W bits, so modular arithmetic on the low bits is exact.
    function automatic logic [DATA_WIDTH-1:0] correct_lane(
        input logic                  sub,
        input logic [DATA_WIDTH:0]   raw
    );
        logic [DATA_WIDTH-1:0] fix;
        if (sub) begin
            if (raw[DATA_WIDTH]) begin
                fix = raw[DATA_WIDTH-1:0] + M_W;
            end else begin
                fix = raw[DATA_WIDTH-1:0];
            end
        end else begin
            if (raw >= {1'b0, M_W}) begin
                fix = raw[DATA_WIDTH-1:0] - M_W;
            end else begin
                fix = raw[DATA_WIDTH-1:0];
            end
        end
        return fix;
    endfunction

    logic                        s1_valid_r;
    logic                        s1_mode_r;
    logic [DATA_WIDTH:0]         s1_raw_r [LANES];
    logic                        s2_valid_r;
    logic [LANES*DATA_WIDTH-1:0] s2_data_r;

    logic                        s1_load_s;
    logic                        s2_load_s;
    logic                        accept_s;
    logic [DATA_WIDTH:0]         raw_s [LANES];
    logic [LANES*DATA_WIDTH-1:0] fixed_s;

    assign s2_load_s = !s2_valid_r || out_ready;
    assign s1_load_s = !s1_valid_r || s2_load_s;
    assign in_ready  = !rst && s1_load_s;
    assign accept_s  = in_valid && in_ready;

    assign out_valid = s2_valid_r;
    assign z_out     = s2_data_r;

    // Raw per-lane sum, or difference whose top bit is the x < y borrow.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (mode) begin
                raw_s[i] = {1'b0, x_in[i*W +: W]} - {1'b0, y_in[i*W +: W]};
            end else begin
                raw_s[i] = {1'b0, x_in[i*W +: W]} + {1'b0, y_in[i*W +: W]};
            end
        end
    end

    // Per-lane correction of the S1 raw values.
    always_comb begin
        fixed_s = '0;
        for (int i = 0; i < LANES; i++) begin
            fixed_s[i*W +: W] = correct_lane(s1_mode_r, s1_raw_r[i]);
        end
    end

    // Stage 1 register: raw result and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_raw_r[i] <= '0;
            end
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mode_r <= mode;
                for (int i = 0; i < LANES; i++) begin
                    s1_raw_r[i] <= raw_s[i];
                end
            end
        end
    end

    // Stage 2 register: corrected result, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= fixed_s;
            end
        end
    end

`ifdef MODADDSUB_RANGE_CHECK_EN
    logic range_hit_s;
    logic range_err_r;

    // Any lane operand at or above the modulus.
    always_comb begin
        range_hit_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((x_in[i*W +: W] >= M_W) || (y_in[i*W +: W] >= M_W)) begin
                range_hit_s = 1'b1;
            end else begin
                range_hit_s = range_hit_s;
            end
        end
    end

    // Sticky range error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_r <= 1'b0;
        end else if (accept_s && range_hit_s) begin
            range_err_r <= 1'b1;
        end
    end

    assign range_err = range_err_r;
`else
    assign range_err = 1'b0;
`endif

endmodule
